regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every register and port word.
REQ-002 Parameter DEPTH, default 32, SHALL set the number of registers; AW = clog2(DEPTH) is a derived localparam.
REQ-003 Parameter NRD, default 2, SHALL set the number of combinational read ports.
REQ-004 Parameter NWR, default 1, SHALL set the number of write ports.
REQ-005 Parameter ZERO_REG, default 1, SHALL make register 0 read as zero and ignore writes to it when 1.
REQ-006 Parameter BYPASS, default 1, SHALL enable same-cycle write-to-read forwarding when 1.
REQ-007 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-008 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-009 we  input  NWR  SHALL hold one write enable per write port.
REQ-010 wa  input  NWR*AW  SHALL hold the packed write addresses, port i at bits [i*AW +: AW].
REQ-011 wd  input  NWR*WIDTH  SHALL hold the packed write data, port i at bits [i*WIDTH +: WIDTH].
REQ-012 ra  input  NRD*AW  SHALL hold the packed read addresses.
REQ-013 rd  output  NRD*WIDTH  SHALL carry the packed read data.
REQ-014 busy  output  1  SHALL be high while the clear sequence runs.

Function
REQ-015 The FSM SHALL have two states: CLEAR and READY.
REQ-016 In CLEAR, a counter SHALL write zero to register cnt on each clock and increment, starting at 0.
REQ-017 When cnt = DEPTH-1 is written, the FSM SHALL enter READY on the next edge; CLEAR therefore lasts exactly DEPTH cycles.
REQ-018 While busy=1, all we SHALL be ignored and every rd word SHALL read 0.
REQ-019 In READY, each port i with we[i]=1 and a valid address SHALL write wd[i] into register wa[i] at the rising edge.
REQ-020 An address is valid only if it is < DEPTH and, when ZERO_REG=1, not 0; invalid writes SHALL be dropped.
REQ-021 When two or more enabled ports target the same address, the highest-indexed port SHALL win.
REQ-022 Each read port SHALL output its register combinationally, with zero latency.
REQ-023 A read of an invalid address SHALL return 0.
REQ-024 With BYPASS=1, a read whose address matches a valid enabled write in the same cycle SHALL return that write's wd, with the highest-indexed match winning.
REQ-025 With BYPASS=0, a read SHALL return the pre-edge register contents.
REQ-026 Registers not written SHALL hold their values indefinitely.

Reset
REQ-027 rst=1 at an edge SHALL set state=CLEAR, cnt=0, busy=1; the next cycle begins clearing.
REQ-028 rst asserted mid-CLEAR SHALL restart the sweep at cnt=0.
REQ-029 Outputs after reset SHALL be busy=1 and all rd=0 until READY.

Structure
REQ-030 Shared package regfile_pkg SHALL hold the state enum (CLEAR, READY) and default WIDTH/DEPTH constants.
REQ-031 Write-port conflict and bypass resolution SHALL live in one sub-module, regfile_wsel, instantiated once per read port and once per register.

Verification
REQ-032 Reset with DEPTH=32 -> busy high for exactly 32 cycles; every rd=0 throughout; a write attempted during busy leaves its register 0 after READY.
REQ-033 Write 0xDEADBEEF to r5 via port 0, then read on ra0=5 -> rd0=0xDEADBEEF the cycle after the edge; with BYPASS=1, rd0=0xDEADBEEF in the write cycle itself.
REQ-034 Write 0x1234 to r0 with ZERO_REG=1 -> rd=0 on every subsequent read of r0.
REQ-035 NWR=2, both ports write r7 (0xAAAA on port 0, 0x5555 on port 1) -> r7=0x5555, and bypass also shows 0x5555.
REQ-036 Assert rst at cnt=10 after filling registers with 0xFF -> sweep restarts at 0, busy lasts 32 more cycles, all registers read 0.
REQ-037 DEPTH=24, write and read address 30 -> write dropped, rd=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Also holds the address-validity rule used by the write and read paths.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;

  // An address is usable only inside the array and, with a hard-wired zero
  // register, never address 0.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input int unsigned depth,
                                   input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Resolves which write port (if any) targets i_addr this cycle.
// Later ports override earlier ones, so the highest-indexed match wins.
module regfile_wsel
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NWR      = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned AW       = 5
) (
  input  logic [AW-1:0]        i_addr,
  input  logic [NWR-1:0]       i_we,
  input  logic [NWR*AW-1:0]    i_wa,
  input  logic [NWR*WIDTH-1:0] i_wd,
  output logic                 o_hit,
  output logic [WIDTH-1:0]     o_data
);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < int'(NWR); i++) begin
      if (i_we[i] && addr_ok(32'(i_wa[i*AW +: AW]), DEPTH, ZERO_REG) &&
          (i_wa[i*AW +: AW] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wd[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset clear sweep, optional zero
// register and optional same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*WIDTH-1:0] wd,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic                 busy,
  output state_t               o_dbg_state
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_busy;

  logic [NWR-1:0]   w_we;
  logic [DEPTH-1:0] w_whit;
  logic [WIDTH-1:0] w_wdat [DEPTH];

  // Writes are dropped while clearing and on a reset edge, so a reset never
  // races a user write into the array.
  assign w_we        = (r_busy || rst) ? '0 : we;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        READY: begin
          r_state <= READY;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_wr
    regfile_wsel #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NWR(NWR), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_wsel (
      .i_addr (AW'(g)),
      .i_we   (w_we),
      .i_wa   (wa),
      .i_wd   (wd),
      .o_hit  (w_whit[g]),
      .o_data (w_wdat[g])
    );
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_state == CLEAR) begin
        if (r_cnt == AW'(i)) r_mem[i] <= '0;
      end else if (w_whit[i]) begin
        r_mem[i] <= w_wdat[i];
      end
    end
  end

  for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic             w_hit;
    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_word;

    assign w_ra = ra[p*AW +: AW];

    regfile_wsel #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NWR(NWR), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_wsel (
      .i_addr (w_ra),
      .i_we   (w_we),
      .i_wa   (wa),
      .i_wd   (wd),
      .o_hit  (w_hit),
      .o_data (w_fwd)
    );

    always_comb begin
      w_word = '0;
      if (!r_busy && addr_ok(32'(w_ra), DEPTH, ZERO_REG)) begin
        w_word = (BYPASS && w_hit) ? w_fwd : r_mem[w_ra];
      end
    end

    assign rd[p*WIDTH +: WIDTH] = w_word;
  end

endmodule
